// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, sequencer states
// and the access legality/alignment rule used by decode and the sequencer.
package lsu_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      ISSUE   = 3'd2,
      WAIT_RD = 3'd3,
      RESP    = 3'd4
   } state_e;

   // True when the access must be answered with an error instead of touching memory.
   function automatic logic access_bad(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
      logic legal;
      case (funct3)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = !we;
         default:          legal = 1'b0;
      endcase
      return !legal
          || (funct3[1:0] == 2'b01 && off[0])
          || (funct3[1:0] == 2'b10 && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte-enables and replicated write data, and
// load-data extraction with sign/zero extension.
module lsu_lane_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wbe,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      o_wbe   = '0;
      o_wdata = '0;
      case (i_funct3[1:0])
         2'b00: begin
            o_wbe   = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            o_wbe   = 4'b0011 << i_off;
            o_wdata = {2{i_wdata[15:0]}};
         end
         2'b10: begin
            o_wbe   = 4'b1111;
            o_wdata = i_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   always_comb begin
      o_rdata = '0;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
         F3_W:    o_rdata = i_rdata;
         F3_BU:   o_rdata = {24'h0, w_byte};
         F3_HU:   o_rdata = {16'h0, w_half};
         default: o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one core access at a time, checks it, issues it on the
// shared data-memory port, waits for read data with a timeout, and returns one response.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_mem_req,
   input  logic        i_mem_gnt,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_wbe,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_resp_valid,
   output logic        o_resp_err,
   output logic [31:0] o_resp_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic              r_req_ready;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [31:0]       r_mem_addr;
   logic [3:0]        r_mem_wbe;
   logic [31:0]       r_mem_wdata;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [31:0]       r_resp_rdata;
   logic              w_accept;
   logic [3:0]        w_wbe;
   logic [31:0]       w_wdata;
   logic [31:0]       w_rdata_ext;

   assign w_accept = i_req_valid && r_req_ready;

   lsu_lane_align u_align (
      .i_funct3 (r_funct3),
      .i_off    (r_addr[1:0]),
      .i_wdata  (r_wdata),
      .i_rdata  (i_mem_rdata),
      .o_wbe    (w_wbe),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata_ext)
   );

   // NOTE: capture registers are pure datapath; the FSM never reads them before an accept, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we     <= i_req_we;
         r_funct3 <= i_req_funct3;
         r_addr   <= i_req_addr;
         r_wdata  <= i_req_wdata;
      end
   end

   // NOTE: non-blocking assignments only, so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_req_ready  <= 1'b1;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wbe    <= '0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_state     <= CHECK;
               end
            end
            CHECK: begin
               if (access_bad(r_we, r_funct3, r_addr[1:0])) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= '0;
                  r_state      <= RESP;
               end else begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= r_we;
                  r_mem_addr  <= {r_addr[31:2], 2'b00};
                  r_mem_wbe   <= r_we ? w_wbe : 4'b0000;
                  r_mem_wdata <= r_we ? w_wdata : 32'h0;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_mem_gnt) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wbe   <= '0;
                  r_mem_wdata <= '0;
                  if (r_mem_we) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b0;
                     r_resp_rdata <= '0;
                     r_state      <= RESP;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               // Read data arriving on the timeout cycle still wins.
               if (i_mem_rvalid) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= w_rdata_ext;
                  r_state      <= RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= '0;
                  r_state      <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
               r_req_ready  <= 1'b1;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_mem_req    = r_mem_req;
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wbe    = r_mem_wbe;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_err   = r_resp_err;
   assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random accesses against a cycle-window model
// built from the access latency, lane and extension rules.
module tb_lsu_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [2:0]  i_req_funct3;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_mem_req;
   logic        i_mem_gnt;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_wbe;
   logic [31:0] o_mem_wdata;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_resp_valid;
   logic        o_resp_err;
   logic [31:0] o_resp_rdata;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_we     (i_req_we),
      .i_req_funct3 (i_req_funct3),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_mem_req    (o_mem_req),
      .i_mem_gnt    (i_mem_gnt),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wbe    (o_mem_wbe),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_resp_valid (o_resp_valid),
      .o_resp_err   (o_resp_err),
      .o_resp_rdata (o_resp_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   // Current expectation: accept cycle, grant cycle, response cycle and the values.
   bit          g_chk    = 1'b0;
   bit          g_active = 1'b0;
   bit          g_bad, g_we, g_err;
   int          g_T, g_G, g_resp;
   logic [31:0] g_addr, g_wdata, g_rdata;
   logic [3:0]  g_wbe;

   logic [31:0] seen_addr, seen_wdata, seen_rdata;
   logic [3:0]  seen_wbe;
   logic        seen_err;
   bit          saw_mreq;
   int          seen_lat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [31:0] addr);
      bit legal;
      int size;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      size = 1 << f3[1:0];
      return (int'(addr[1:0]) % size) != 0;
   endfunction

   function automatic logic [3:0] m_wbe(input logic [2:0] f3, input logic [31:0] addr);
      int size;
      size = 1 << f3[1:0];
      return 4'(((1 << size) - 1) << addr[1:0]);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wdata);
      case (f3[1:0])
         2'd0:    return {24'h0, wdata[7:0]} * 32'h0101_0101;
         2'd1:    return {16'h0, wdata[15:0]} * 32'h0001_0001;
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      logic [31:0] v;
      v = rdata >> (8 * addr[1:0]);
      case (f3)
         3'd0: begin v = v & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
         3'd1: begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
         3'd4: v = v & 32'hFF;
         3'd5: v = v & 32'hFFFF;
         default: v = rdata;
      endcase
      return v;
   endfunction

   // Per-cycle comparison against the expected windows.
   always @(negedge clk) begin
      bit busy, mreq, rv;
      if (g_chk) begin
         busy = g_active && cyc > g_T && cyc <= g_resp;
         mreq = g_active && !g_bad && cyc >= g_T + 2 && cyc <= g_G;
         rv   = g_active && cyc == g_resp;
         check("req_ready", 32'(o_req_ready), 32'(!busy));
         check("mem_req", 32'(o_mem_req), 32'(mreq));
         check("resp_valid", 32'(o_resp_valid), 32'(rv));
         if (o_mem_req) saw_mreq = 1'b1;
         if (mreq) begin
            check("mem_addr", o_mem_addr, g_addr);
            check("mem_we", 32'(o_mem_we), 32'(g_we));
            check("mem_wbe", 32'(o_mem_wbe), 32'(g_wbe));
            check("mem_wdata", o_mem_wdata, g_wdata);
            seen_addr  = o_mem_addr;
            seen_wbe   = o_mem_wbe;
            seen_wdata = o_mem_wdata;
         end else begin
            check("wbe_idle", 32'(o_mem_wbe), 32'h0);
            check("wdata_idle", o_mem_wdata, 32'h0);
         end
         if (rv) begin
            check("resp_err", 32'(o_resp_err), 32'(g_err));
            check("resp_rdata", o_resp_rdata, g_rdata);
            seen_lat   = cyc - g_T;
            seen_err   = o_resp_err;
            seen_rdata = o_resp_rdata;
         end
      end
   end

   task automatic idle(input int n, input bit force_rv);
      for (int k = 0; k < n; k++) begin
         i_req_valid  = 1'b0;
         i_mem_gnt    = 1'($urandom);
         i_mem_rvalid = force_rv ? 1'b1 : 1'($urandom);
         i_mem_rdata  = $urandom;
         @(posedge clk); #1;
      end
   endtask

   // Drives one access from acceptance to its response; rd < 0 means read data never comes.
   task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gd, input int rd,
                          input logic [31:0] rdata);
      int r_cyc, rv_end;
      g_T     = cyc;
      g_bad   = m_bad(we, f3, addr);
      g_we    = we;
      g_addr  = {addr[31:2], 2'b00};
      g_wbe   = we ? m_wbe(f3, addr) : 4'h0;
      g_wdata = we ? m_wdata(f3, wdata) : 32'h0;
      g_G     = g_T + 2 + gd;
      r_cyc   = g_G + 1 + rd;
      rv_end  = (rd >= 0) ? r_cyc : g_G + TO;
      g_rdata = 32'h0;
      if (g_bad) begin
         g_resp = g_T + 2; g_err = 1'b1;
      end else if (we) begin
         g_resp = g_G + 1; g_err = 1'b0;
      end else if (rd >= 0) begin
         g_resp = r_cyc + 1; g_err = 1'b0; g_rdata = m_load(f3, addr, rdata);
      end else begin
         g_resp = g_G + TO + 1; g_err = 1'b1;
      end
      saw_mreq = 1'b0;
      seen_lat = -1;
      g_active = 1'b1;
      while (cyc <= g_resp) begin
         if (cyc == g_T) begin
            i_req_valid  = 1'b1;
            i_req_we     = we;
            i_req_funct3 = f3;
            i_req_addr   = addr;
            i_req_wdata  = wdata;
         end else begin
            i_req_valid  = 1'($urandom);
            i_req_we     = 1'($urandom);
            i_req_funct3 = 3'($urandom);
            i_req_addr   = $urandom;
            i_req_wdata  = $urandom;
         end
         if (!g_bad && cyc >= g_T + 2 && cyc <= g_G) i_mem_gnt = (cyc == g_G);
         else i_mem_gnt = 1'($urandom);
         if (!g_bad && !we && cyc > g_G && cyc <= rv_end) i_mem_rvalid = (rd >= 0 && cyc == r_cyc);
         else i_mem_rvalid = 1'($urandom);
         i_mem_rdata = (!g_bad && !we && rd >= 0 && cyc == r_cyc) ? rdata : $urandom;
         @(posedge clk); #1;
      end
      i_req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'h0;
      i_req_addr = 32'h0; i_req_wdata = 32'h0;
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(o_req_ready), 32'h1);
      check("rst_mem_req", 32'(o_mem_req), 32'h0);
      check("rst_resp_valid", 32'(o_resp_valid), 32'h0);
      check("rst_wbe", 32'(o_mem_wbe), 32'h0);
      check("rst_addr", o_mem_addr, 32'h0);
      check("rst_rdata", o_resp_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      g_chk = 1'b1;
      idle(2, 1'b0);

      // Byte store into the top lane.
      run_txn(1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 0, 0, 32'h0);
      check("sb_addr", seen_addr, 32'h1000);
      check("sb_wbe", 32'(seen_wbe), 32'h8);
      check("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
      check("sb_lat", 32'(seen_lat), 32'd3);
      check("sb_err", 32'(seen_err), 32'h0);
      idle(1, 1'b0);

      // Loads: lane 1 of 0x80FF is 0x80.
      run_txn(1'b0, 3'd0, 32'h2001, 32'h0, 0, 0, 32'h0000_80FF);
      check("lb_rdata", seen_rdata, 32'hFFFF_FF80);
      check("lb_lat", 32'(seen_lat), 32'd4);
      run_txn(1'b0, 3'd4, 32'h2001, 32'h0, 0, 0, 32'h0000_80FF);
      check("lbu_rdata", seen_rdata, 32'h0000_0080);
      run_txn(1'b0, 3'd5, 32'h2002, 32'h0, 0, 0, 32'h8000_1234);
      check("lhu_rdata", seen_rdata, 32'h0000_8000);

      // Misaligned word load and half store.
      run_txn(1'b0, 3'd2, 32'h3002, 32'h0, 0, 0, 32'h0);
      check("lw_mis_err", 32'(seen_err), 32'h1);
      check("lw_mis_lat", 32'(seen_lat), 32'd2);
      check("lw_mis_noreq", 32'(saw_mreq), 32'h0);
      run_txn(1'b1, 3'd1, 32'h3001, 32'h1234_5678, 0, 0, 32'h0);
      check("sh_mis_err", 32'(seen_err), 32'h1);
      check("sh_mis_noreq", 32'(saw_mreq), 32'h0);

      // Ten cycles without grant.
      run_txn(1'b1, 3'd1, 32'h4002, 32'hDEAD_BEEF, 10, 0, 32'h0);
      check("stall_lat", 32'(seen_lat), 32'd13);
      check("stall_wbe", 32'(seen_wbe), 32'hC);
      check("stall_wdata", seen_wdata, 32'hBEEF_BEEF);

      // Timeout, stray read data afterwards, then data on the timeout cycle.
      run_txn(1'b0, 3'd2, 32'h5000, 32'h0, 0, -1, 32'h0);
      check("to_err", 32'(seen_err), 32'h1);
      check("to_lat", 32'(seen_lat), 32'd11);
      idle(3, 1'b1);
      run_txn(1'b0, 3'd2, 32'h5004, 32'h0, 0, 7, 32'hCAFE_F00D);
      check("to_edge_err", 32'(seen_err), 32'h0);
      check("to_edge_rdata", seen_rdata, 32'hCAFE_F00D);
      check("to_edge_lat", 32'(seen_lat), 32'd11);

      // Reset while waiting for read data.
      g_chk = 1'b0; g_active = 1'b0;
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'd2; i_req_addr = 32'h6000;
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      @(posedge clk); #1;
      i_mem_gnt = 1'b1;
      @(posedge clk); #1;
      i_mem_gnt = 1'b0;
      @(negedge clk);
      check("rd_wait_busy", 32'(o_req_ready), 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = $urandom;
         @(negedge clk);
         check("rstmid_ready", 32'(o_req_ready), 32'h1);
         check("rstmid_noresp", 32'(o_resp_valid), 32'h0);
         check("rstmid_noreq", 32'(o_mem_req), 32'h0);
         @(posedge clk); #1;
      end
      i_mem_rvalid = 1'b0;
      g_chk = 1'b1;
      run_txn(1'b0, 3'd2, 32'h0, 32'h0, 1, 2, 32'h1357_9BDF);
      check("post_rst_rdata", seen_rdata, 32'h1357_9BDF);
      check("post_rst_err", 32'(seen_err), 32'h0);

      // Random mix.
      for (int n = 0; n < 300; n++) begin
         bit we;
         logic [2:0] f3;
         int gd, rd;
         we = 1'($urandom);
         if ($urandom_range(0, 9) < 8) begin
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
               f3 = 3'($urandom_range(0, 4));
               if (f3 == 3'd3) f3 = 3'd5;
            end
         end else begin
            f3 = 3'($urandom);
         end
         gd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3));
         rd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 7));
         run_txn(we, f3, $urandom, $urandom, gd, rd, $urandom);
         idle(int'($urandom_range(0, 2)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
